// File: rtl/mult_seq_pkg.sv
// Shared definitions for the shift-and-add multiplier sequencer.
// Contents:
//   - 3-bit state encodings and the state_t enum built from them
//   - Booth {Q0,Q_M1} pair codes used when MULT_SEQUENCER_BOOTH_EN is defined
//   - ctrl_t: the bundle of datapath strobes plus BUSY/DONE
//   - decode_ctrl(): Moore decode of a state into ctrl_t
package mult_seq_pkg;

   localparam logic [2:0] ENC_IDLE  = 3'd0;
   localparam logic [2:0] ENC_LOAD  = 3'd1;
   localparam logic [2:0] ENC_TEST  = 3'd2;
   localparam logic [2:0] ENC_ADD   = 3'd3;
   localparam logic [2:0] ENC_SUB   = 3'd4;
   localparam logic [2:0] ENC_SHIFT = 3'd5;
   localparam logic [2:0] ENC_FIN   = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE  = ENC_IDLE,
      S_LOAD  = ENC_LOAD,
      S_TEST  = ENC_TEST,
      S_ADD   = ENC_ADD,
      S_SUB   = ENC_SUB,
      S_SHIFT = ENC_SHIFT,
      S_FIN   = ENC_FIN
   } state_t;

   // Booth pair codes, ordered {Q0, Q_M1}
   localparam logic [1:0] PAIR_SUB = 2'b10;
   localparam logic [1:0] PAIR_ADD = 2'b01;

   typedef struct packed {
      logic clr_a;
      logic ldq;
      logic ldm;
      logic lda;
      logic add_en;
      logic sub_en;
      logic sr;
      logic asr;
      logic busy;
      logic done;
   } ctrl_t;

   // Strobes for one state. SUB-related and ASR strobes only exist in Booth mode,
   // so they are gated by 'booth' and become constant 0 otherwise.
   function automatic ctrl_t decode_ctrl(input state_t s, input logic booth);
      ctrl_t c;
      c      = ctrl_t'(10'b0);
      c.busy = (s != S_IDLE);
      case (s)
         S_LOAD: begin
            c.clr_a = 1'b1;
            c.ldq   = 1'b1;
            c.ldm   = 1'b1;
         end
         S_ADD: begin
            c.lda    = 1'b1;
            c.add_en = 1'b1;
         end
         S_SUB: begin
            c.lda    = booth;
            c.sub_en = booth;
         end
         S_SHIFT: begin
            c.sr  = 1'b1;
            c.asr = booth;
         end
         S_FIN:   c.done = 1'b1;
         default: c.done = 1'b0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// Bit counter for the multiplier sequencer.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0 (has priority over inc)
//   inc      : increment by one
//   cnt      : current count (CW bits)
//   tc       : terminal count, high when cnt == WIDTH-1
module mult_bit_counter #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          tc
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] ZERO = CW'(0);

   // Count register; the sequencer never increments past LAST, so no wrap logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= ZERO;
      end else if (clr) begin
         cnt <= ZERO;
      end else if (inc) begin
         cnt <= cnt + ONE;
      end else begin
         cnt <= cnt;
      end
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/mult_sequencer.sv
// Control sequencer for a shift-and-add multiplier datapath (A, Q, M registers).
// A START pulse in IDLE runs LOAD, then WIDTH rounds of TEST/[ADD|SUB]/SHIFT,
// then a one-cycle FIN with DONE high; product is then valid in A:Q.
// Build option: define MULT_SEQUENCER_BOOTH_EN for radix-2 Booth (signed)
// operation; otherwise plain unsigned shift-add (SUB_EN/ASR stay 0, Q_M1 unused).
// Ports:
//   CLK, RST   : clock (rising edge), asynchronous active-high reset
//   START      : operation request, only honoured in IDLE
//   Q0, Q_M1   : Q LSB and Booth extra bit, looked at only in TEST
//   CLR_A, LDQ, LDM, LDA, ADD_EN, SUB_EN, SR, ASR : datapath strobes
//   BUSY       : high outside IDLE
//   DONE       : one-cycle pulse when the product is valid
//   CNT        : number of bits processed so far
module mult_sequencer
   import mult_seq_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic          Q0,
   input  logic          Q_M1,
   output logic          CLR_A,
   output logic          LDQ,
   output logic          LDM,
   output logic          LDA,
   output logic          ADD_EN,
   output logic          SUB_EN,
   output logic          SR,
   output logic          ASR,
   output logic          BUSY,
   output logic          DONE,
   output logic [CW-1:0] CNT
);

`ifdef MULT_SEQUENCER_BOOTH_EN
   localparam logic BOOTH = 1'b1;
`else
   localparam logic BOOTH = 1'b0;
   logic unused_q_m1;
   assign unused_q_m1 = Q_M1;
`endif

   state_t state;
   state_t next_state;
   ctrl_t  ctrl_r;
   logic   cnt_clr;
   logic   cnt_inc;
   logic   cnt_tc;

   mult_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk (CLK),
      .rst (RST),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .cnt (CNT),
      .tc  (cnt_tc)
   );

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Outputs are registered from the decode of the next state, so they are
   // cycle-for-cycle the Moore decode of 'state' but leave the block glitch-free.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ctrl_r <= decode_ctrl(S_IDLE, BOOTH);
      end else begin
         ctrl_r <= decode_ctrl(next_state, BOOTH);
      end
   end

   // Next-state and counter control
   always_comb begin
      next_state = state;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      case (state)
         S_IDLE: begin
            if (START) begin
               next_state = S_LOAD;
            end else begin
               next_state = S_IDLE;
            end
         end
         S_LOAD: begin
            cnt_clr    = 1'b1;
            next_state = S_TEST;
         end
         S_TEST: begin
`ifdef MULT_SEQUENCER_BOOTH_EN
            case ({Q0, Q_M1})
               PAIR_SUB: next_state = S_SUB;
               PAIR_ADD: next_state = S_ADD;
               default:  next_state = S_SHIFT;
            endcase
`else
            if (Q0) begin
               next_state = S_ADD;
            end else begin
               next_state = S_SHIFT;
            end
`endif
         end
         S_ADD:   next_state = S_SHIFT;
         S_SUB:   next_state = S_SHIFT;
         S_SHIFT: begin
            // Last bit done: hold CNT at WIDTH-1 through FIN
            if (cnt_tc) begin
               next_state = S_FIN;
            end else begin
               cnt_inc    = 1'b1;
               next_state = S_TEST;
            end
         end
         S_FIN:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   assign CLR_A  = ctrl_r.clr_a;
   assign LDQ    = ctrl_r.ldq;
   assign LDM    = ctrl_r.ldm;
   assign LDA    = ctrl_r.lda;
   assign ADD_EN = ctrl_r.add_en;
   assign SUB_EN = ctrl_r.sub_en;
   assign SR     = ctrl_r.sr;
   assign ASR    = ctrl_r.asr;
   assign BUSY   = ctrl_r.busy;
   assign DONE   = ctrl_r.done;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer.
// Two instances (WIDTH=4 and WIDTH=8) each drive a small A/Q/M datapath model
// that feeds Q0/Q_M1 back, so latency, strobe counts and products can be checked.
// Works for both the default build and MULT_SEQUENCER_BOOTH_EN.
module tb_mult_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- WIDTH=4 instance and datapath model ----------------
   logic       start4 = 1'b0;
   logic       s4_clr_a, s4_ldq, s4_ldm, s4_lda, s4_add_en, s4_sub_en, s4_sr, s4_asr, s4_busy, s4_done;
   logic [1:0] s4_cnt;
   logic [3:0] a4, q4, m4, mq4, mm4;
   logic       c4, qm4;

   mult_sequencer #(.WIDTH(4)) u4 (
      .CLK(clk), .RST(rst), .START(start4), .Q0(q4[0]), .Q_M1(qm4),
      .CLR_A(s4_clr_a), .LDQ(s4_ldq), .LDM(s4_ldm), .LDA(s4_lda),
      .ADD_EN(s4_add_en), .SUB_EN(s4_sub_en), .SR(s4_sr), .ASR(s4_asr),
      .BUSY(s4_busy), .DONE(s4_done), .CNT(s4_cnt)
   );

   always @(posedge clk) begin
      if (rst) begin
         a4 <= 4'h0; q4 <= 4'h0; m4 <= 4'h0; c4 <= 1'b0; qm4 <= 1'b0;
      end else begin
         if (s4_clr_a) begin a4 <= 4'h0; c4 <= 1'b0; end
         if (s4_ldq) begin q4 <= mq4; qm4 <= 1'b0; end
         if (s4_ldm) m4 <= mm4;
         if (s4_lda) begin
            if (s4_sub_en) {c4, a4} <= {1'b0, a4} - {1'b0, m4};
            else           {c4, a4} <= {1'b0, a4} + {1'b0, m4};
         end
         if (s4_sr) begin
            qm4 <= q4[0];
            if (s4_asr) begin
               a4 <= {a4[3], a4[3:1]};
               q4 <= {a4[0], q4[3:1]};
            end else begin
               {c4, a4, q4} <= {1'b0, c4, a4, q4[3:1]};
            end
         end
      end
   end

   // ---------------- WIDTH=8 instance and datapath model ----------------
   logic       start8 = 1'b0;
   logic       s8_clr_a, s8_ldq, s8_ldm, s8_lda, s8_add_en, s8_sub_en, s8_sr, s8_asr, s8_busy, s8_done;
   logic [2:0] s8_cnt;
   logic [7:0] a8, q8, m8, mq8, mm8;
   logic       c8, qm8;

   mult_sequencer #(.WIDTH(8)) u8 (
      .CLK(clk), .RST(rst), .START(start8), .Q0(q8[0]), .Q_M1(qm8),
      .CLR_A(s8_clr_a), .LDQ(s8_ldq), .LDM(s8_ldm), .LDA(s8_lda),
      .ADD_EN(s8_add_en), .SUB_EN(s8_sub_en), .SR(s8_sr), .ASR(s8_asr),
      .BUSY(s8_busy), .DONE(s8_done), .CNT(s8_cnt)
   );

   always @(posedge clk) begin
      if (rst) begin
         a8 <= 8'h00; q8 <= 8'h00; m8 <= 8'h00; c8 <= 1'b0; qm8 <= 1'b0;
      end else begin
         if (s8_clr_a) begin a8 <= 8'h00; c8 <= 1'b0; end
         if (s8_ldq) begin q8 <= mq8; qm8 <= 1'b0; end
         if (s8_ldm) m8 <= mm8;
         if (s8_lda) begin
            if (s8_sub_en) {c8, a8} <= {1'b0, a8} - {1'b0, m8};
            else           {c8, a8} <= {1'b0, a8} + {1'b0, m8};
         end
         if (s8_sr) begin
            qm8 <= q8[0];
            if (s8_asr) begin
               a8 <= {a8[7], a8[7:1]};
               q8 <= {a8[0], q8[7:1]};
            end else begin
               {c8, a8, q8} <= {1'b0, c8, a8, q8[7:1]};
            end
         end
      end
   end

`ifdef MULT_SEQUENCER_BOOTH_EN
   localparam int EXP_ASR4  = 4;
   localparam int EXP_ADD03 = 1;
   localparam int EXP_SUB03 = 1;
`else
   localparam int EXP_ASR4  = 0;
   localparam int EXP_ADD03 = 2;
   localparam int EXP_SUB03 = 0;
`endif

   // Runs one WIDTH=4 operation and measures it; the calling test does the checks.
   // Latency k = DONE is high at the k-th edge after the START sampling edge.
   task automatic op4(input logic [3:0] mq, input logic [3:0] mc, input bit hold,
                      output int lat, output int nsr, output int nasr, output int nadd,
                      output int nsub, output int ndone, output int nbusy,
                      output logic [7:0] prod, output logic [7:0] seq, output logic [1:0] cnt_done);
      int tail;
      lat = -1; nsr = 0; nasr = 0; nadd = 0; nsub = 0; ndone = 0; nbusy = 0;
      prod = 8'h00; seq = 8'h00; cnt_done = 2'd0; tail = -1;
      @(negedge clk);
      mq4 = mq; mm4 = mc; start4 = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start4 = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (s4_busy)   nbusy++;
         if (s4_sr)     nsr++;
         if (s4_asr)    nasr++;
         if (s4_add_en) begin nadd++; seq = {seq[5:0], 2'b01}; end
         if (s4_sub_en) begin nsub++; seq = {seq[5:0], 2'b10}; end
         if (s4_done) begin
            ndone++;
            if (lat < 0) begin
               lat = k; prod = {a4, q4}; cnt_done = s4_cnt; tail = k + 4;
               start4 = 1'b0;
            end
         end
         if (k == tail) break;
      end
   endtask

   task automatic test_reset;
      #3;
      total++;
      if ({s4_clr_a, s4_ldq, s4_ldm, s4_lda, s4_add_en, s4_sub_en, s4_sr, s4_asr, s4_busy, s4_done} !== 10'b0) begin
         bad++; $display("FAIL reset_outputs_w4 got=%b want=0", {s4_clr_a, s4_ldq, s4_ldm, s4_lda, s4_add_en, s4_sub_en, s4_sr, s4_asr, s4_busy, s4_done});
      end
      total++;
      if ({s8_clr_a, s8_ldq, s8_ldm, s8_lda, s8_add_en, s8_sub_en, s8_sr, s8_asr, s8_busy, s8_done} !== 10'b0) begin
         bad++; $display("FAIL reset_outputs_w8 got=%b want=0", {s8_clr_a, s8_ldq, s8_ldm, s8_lda, s8_add_en, s8_sub_en, s8_sr, s8_asr, s8_busy, s8_done});
      end
      total++;
      if ({s4_cnt, s8_cnt} !== 5'b0) begin bad++; $display("FAIL reset_cnt got=%b want=0", {s4_cnt, s8_cnt}); end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (s4_busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%b want=0", s4_busy); end
   endtask

   task automatic test_zero_multiplier;
      int lat, nsr, nasr, nadd, nsub, ndone, nbusy;
      logic [7:0] prod, seq;
      logic [1:0] cd;
      op4(4'b0000, 4'b0110, 1'b0, lat, nsr, nasr, nadd, nsub, ndone, nbusy, prod, seq, cd);
      total++; if (lat !== 10)       begin bad++; $display("FAIL zero_latency got=%0d want=10", lat); end
      total++; if (nbusy !== 10)     begin bad++; $display("FAIL zero_busy_cycles got=%0d want=10", nbusy); end
      total++; if (nsr !== 4)        begin bad++; $display("FAIL zero_sr_count got=%0d want=4", nsr); end
      total++; if (nasr !== EXP_ASR4) begin bad++; $display("FAIL zero_asr_count got=%0d want=%0d", nasr, EXP_ASR4); end
      total++; if (nadd + nsub !== 0) begin bad++; $display("FAIL zero_alu_ops got=%0d want=0", nadd + nsub); end
      total++; if (ndone !== 1)      begin bad++; $display("FAIL zero_done_count got=%0d want=1", ndone); end
      total++; if (cd !== 2'd3)      begin bad++; $display("FAIL zero_cnt_at_done got=%0d want=3", cd); end
      total++; if (prod !== 8'h00)   begin bad++; $display("FAIL zero_product got=%h want=00", prod); end
   endtask

`ifndef MULT_SEQUENCER_BOOTH_EN
   task automatic test_unsigned;
      int lat, nsr, nasr, nadd, nsub, ndone, nbusy;
      logic [7:0] prod, seq;
      logic [1:0] cd;
      op4(4'b1011, 4'b0110, 1'b0, lat, nsr, nasr, nadd, nsub, ndone, nbusy, prod, seq, cd);
      total++; if (lat !== 13)     begin bad++; $display("FAIL unsigned_latency got=%0d want=13", lat); end
      total++; if (prod !== 8'h42) begin bad++; $display("FAIL unsigned_product got=%h want=42", prod); end
      total++; if (nadd !== 3)     begin bad++; $display("FAIL unsigned_add_count got=%0d want=3", nadd); end
      total++; if (nsub !== 0)     begin bad++; $display("FAIL unsigned_sub_count got=%0d want=0", nsub); end
      total++; if (nsr !== 4)      begin bad++; $display("FAIL unsigned_sr_count got=%0d want=4", nsr); end
      total++; if (ndone !== 1)    begin bad++; $display("FAIL unsigned_done_count got=%0d want=1", ndone); end
   endtask
`else
   task automatic test_booth;
      int lat, nsr, nasr, nadd, nsub, ndone, nbusy;
      logic [7:0] prod, seq;
      logic [1:0] cd;
      op4(4'b0101, 4'b1101, 1'b0, lat, nsr, nasr, nadd, nsub, ndone, nbusy, prod, seq, cd);
      total++; if (lat !== 14)     begin bad++; $display("FAIL booth_latency got=%0d want=14", lat); end
      total++; if (prod !== 8'hF1) begin bad++; $display("FAIL booth_product got=%h want=f1", prod); end
      total++; if (seq !== 8'h99)  begin bad++; $display("FAIL booth_op_sequence got=%h want=99", seq); end
      total++; if (nasr !== 4)     begin bad++; $display("FAIL booth_asr_count got=%0d want=4", nasr); end
      total++; if (ndone !== 1)    begin bad++; $display("FAIL booth_done_count got=%0d want=1", ndone); end
   endtask
`endif

   // START held high for the whole operation: no re-trigger while busy
   task automatic test_start_hold;
      int lat, nsr, nasr, nadd, nsub, ndone, nbusy;
      logic [7:0] prod, seq;
      logic [1:0] cd;
      op4(4'b0011, 4'b0101, 1'b1, lat, nsr, nasr, nadd, nsub, ndone, nbusy, prod, seq, cd);
      total++; if (lat !== 12)        begin bad++; $display("FAIL hold_latency got=%0d want=12", lat); end
      total++; if (ndone !== 1)       begin bad++; $display("FAIL hold_done_count got=%0d want=1", ndone); end
      total++; if (nbusy !== 12)      begin bad++; $display("FAIL hold_busy_cycles got=%0d want=12", nbusy); end
      total++; if (nadd !== EXP_ADD03) begin bad++; $display("FAIL hold_add_count got=%0d want=%0d", nadd, EXP_ADD03); end
      total++; if (nsub !== EXP_SUB03) begin bad++; $display("FAIL hold_sub_count got=%0d want=%0d", nsub, EXP_SUB03); end
      total++; if (prod !== 8'h0F)    begin bad++; $display("FAIL hold_product got=%h want=0f", prod); end
   endtask

   // Reset during the first LDA cycle of a WIDTH=8 operation
   task automatic test_reset_mid_op;
      int nd, nb;
      @(negedge clk);
      mq8 = 8'hA5; mm8 = 8'h37; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (s8_lda !== 1'b1) begin bad++; $display("FAIL midop_lda_before_reset got=%b want=1", s8_lda); end
      rst = 1'b1;
      #1;
      total++;
      if ({s8_clr_a, s8_ldq, s8_ldm, s8_lda, s8_add_en, s8_sub_en, s8_sr, s8_asr, s8_busy, s8_done} !== 10'b0) begin
         bad++; $display("FAIL midop_async_outputs got=%b want=0", {s8_clr_a, s8_ldq, s8_ldm, s8_lda, s8_add_en, s8_sub_en, s8_sr, s8_asr, s8_busy, s8_done});
      end
      total++; if (s8_cnt !== 3'd0) begin bad++; $display("FAIL midop_cnt got=%0d want=0", s8_cnt); end
      @(negedge clk);
      rst = 1'b0;
      nd = 0; nb = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (s8_done) nd++;
         if (s8_busy) nb++;
      end
      total++; if (nd !== 0) begin bad++; $display("FAIL midop_no_done got=%0d want=0", nd); end
      total++; if (nb !== 0) begin bad++; $display("FAIL midop_stays_idle got=%0d want=0", nb); end
   endtask

   // START held high on WIDTH=8: two operations with exactly one IDLE cycle between
   task automatic test_back_to_back;
      int d1, d2;
      logic [15:0] prod2;
      d1 = -1; d2 = -1; prod2 = 16'h0;
      @(negedge clk);
      mq8 = 8'h03; mm8 = 8'h05; start8 = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 120; k++) begin
         @(negedge clk);
         if (s8_done) begin
            if (d1 < 0) begin
               d1 = k;
               total++; if (s8_cnt !== 3'd7) begin bad++; $display("FAIL b2b_cnt_at_done got=%0d want=7", s8_cnt); end
            end else begin
               d2 = k; prod2 = {a8, q8}; start8 = 1'b0;
               break;
            end
         end
         if (d1 > 0 && k == d1 + 1) begin
            total++; if (s8_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap got=%b want=0", s8_busy); end
         end
         if (d1 > 0 && k == d1 + 2) begin
            total++; if (s8_clr_a !== 1'b1) begin bad++; $display("FAIL b2b_reload got=%b want=1", s8_clr_a); end
         end
         if (d1 > 0 && k == d1 + 3) begin
            total++; if (s8_cnt !== 3'd0) begin bad++; $display("FAIL b2b_cnt_reloaded got=%0d want=0", s8_cnt); end
         end
      end
      start8 = 1'b0;
      total++; if (d1 !== 20)      begin bad++; $display("FAIL b2b_first_latency got=%0d want=20", d1); end
      total++; if (d2 - d1 !== 21) begin bad++; $display("FAIL b2b_done_spacing got=%0d want=21", d2 - d1); end
      total++; if (prod2 !== 16'h000F) begin bad++; $display("FAIL b2b_product got=%h want=000f", prod2); end
      repeat (3) @(negedge clk);
      total++; if (s8_busy !== 1'b0) begin bad++; $display("FAIL b2b_final_idle got=%b want=0", s8_busy); end
   endtask

   initial begin
      mq4 = 4'h0; mm4 = 4'h0; mq8 = 8'h00; mm8 = 8'h00;
      test_reset;
      test_zero_multiplier;
`ifndef MULT_SEQUENCER_BOOTH_EN
      test_unsigned;
`else
      test_booth;
`endif
      test_start_hold;
      test_reset_mid_op;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
